hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, giving the mispredict flush length in cycles (legal range 1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port idex_memread, input, 1: the ID/EX instruction is a load.
REQ-005 SHALL have port idex_rd, input, 5: the ID/EX destination register.
REQ-006 SHALL have ports ifid_rs1 and ifid_rs2, input, 5 each: the IF/ID source registers.
REQ-007 SHALL have port ifid_uses_rs2, input, 1: the IF/ID instruction reads rs2 (0 for immediate forms).
REQ-008 SHALL have port ex_mispredict, input, 1: the branch resolved in EX this cycle was mispredicted.
REQ-009 SHALL have port pc_write, output, 1: the PC may update.
REQ-010 SHALL have port ifid_write, output, 1: the IF/ID register may load.
REQ-011 SHALL have port idex_bubble, output, 1: insert a NOP into ID/EX.
REQ-012 SHALL have ports ifid_flush and idex_flush, output, 1 each: clear that pipeline register.
REQ-013 SHALL have port pcsrc_counter, output, 3: the pipeline-refill count that gates forwarding.
REQ-014 SHALL have ports stall_count and flush_count, output, 16 each: event statistics.

Function
REQ-015 SHALL implement an FSM with registered states RUN, STALL and FLUSH; outputs are combinational from the state and the current inputs.
REQ-016 SHALL define load-use as: idex_memread=1, idex_rd!=0, and either idex_rd==ifid_rs1 or (ifid_uses_rs2=1 and idex_rd==ifid_rs2).
REQ-017 In RUN with no event, SHALL drive pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, idex_flush=0.
REQ-018 On load-use in RUN, SHALL drive pc_write=0, ifid_write=0, idex_bubble=1 in the same cycle, then go to STALL.
REQ-019 STALL SHALL last exactly 1 cycle with load-use detection masked and RUN-default outputs, then return to RUN.
REQ-020 On ex_mispredict in RUN or STALL, SHALL drive ifid_flush=1, idex_flush=1, pc_write=1 in the same cycle; mispredict has priority over a simultaneous load-use, which is discarded.
REQ-021 After a mispredict, SHALL go to FLUSH for FLUSH_CYCLES-1 further cycles, or straight to RUN when FLUSH_CYCLES=1.
REQ-022 In FLUSH, SHALL hold ifid_flush=1, idex_flush=1, pc_write=1, ignore ex_mispredict and load-use, and count the remaining cycles with an internal 2-bit down-counter.
REQ-023 pcsrc_counter SHALL clear to 0 on any cycle asserting the flush outputs.
REQ-024 Otherwise, pcsrc_counter SHALL increment by 1 in each cycle with pc_write=1, saturate at 3'b111, and hold when pc_write=0.
REQ-025 stall_count SHALL increment once per load-use stall and saturate at 16'hFFFF.
REQ-026 flush_count SHALL increment once per accepted mispredict (not per FLUSH cycle) and saturate at 16'hFFFF.
REQ-027 A mispredict in the last FLUSH cycle SHALL be ignored; one accepted in RUN on the cycle after FLUSH SHALL restart the flush.

Reset
REQ-028 While rst_n=0 at a rising edge, SHALL set state=RUN, pcsrc_counter=0, stall_count=0, flush_count=0 and the flush down-counter=0.
REQ-029 During reset cycles, SHALL drive pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, idex_flush=0.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL abort that operation, with no residual stall or flush after rst_n rises.

Structure
REQ-031 State encodings (RUN=2'd0, STALL=2'd1, FLUSH=2'd2) and the counter widths SHALL live in the shared hazard package header.
REQ-032 SHALL instantiate one sub-module, sat_counter (parameterised width, synchronous clear, enable, saturating increment), three times: pcsrc_counter, stall_count, flush_count.

Verification
REQ-033 Reset then 8 idle cycles -> pcsrc_counter reads 1,2,...,7,7; pc_write=1 throughout.
REQ-034 idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> one cycle with pc_write=0 and idex_bubble=1, stall_count=1, pcsrc_counter held; with idex_rd=0 -> no stall.
REQ-035 Load-use and ex_mispredict in the same cycle -> flush only; stall_count unchanged, flush_count=1, pcsrc_counter=0 next cycle.
REQ-036 FLUSH_CYCLES=3, mispredict at cycle N -> flush outputs high in N..N+2, a mispredict at N+1 is ignored, flush_count=1, RUN at N+3.
REQ-037 rst_n low for one cycle during STALL or FLUSH -> next cycle in RUN, all counters 0, flush outputs 0.
REQ-038 Force stall_count to 16'hFFFF, then trigger one more load-use -> stall_count stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard control unit.
package hazard_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  localparam int REG_W       = 5;
  localparam int PCSRC_W     = 3;
  localparam int STAT_W      = 16;
  localparam int FLUSH_CNT_W = 2;
endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)                              q <= '0;
    else if (clr)                            q <= '0;
    else if (en && (q != {WIDTH{1'b1}}))     q <= q + WIDTH'(1);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall / mispredict flush control for a 5-stage pipeline.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               idex_memread,
  input  logic [REG_W-1:0]   idex_rd,
  input  logic [REG_W-1:0]   ifid_rs1,
  input  logic [REG_W-1:0]   ifid_rs2,
  input  logic               ifid_uses_rs2,
  input  logic               ex_mispredict,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [PCSRC_W-1:0] pcsrc_counter,
  output logic [STAT_W-1:0]  stall_count,
  output logic [STAT_W-1:0]  flush_count
);
  // Remaining FLUSH-state cycles after the mispredict cycle, minus one.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 1) ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;

  hz_state_e              state, state_nxt;
  logic [FLUSH_CNT_W-1:0] fcnt, fcnt_nxt;
  logic                   load_use, flush, stall_evt, mp_evt;

  assign load_use = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    stall_evt   = 1'b0;
    mp_evt      = 1'b0;
    // Outputs fall back to RUN defaults while reset is held.
    if (rst_n) begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (ex_mispredict) begin
            flush     = 1'b1;
            mp_evt    = 1'b1;
            fcnt_nxt  = FLUSH_LOAD;
            state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if ((state == ST_RUN) && load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
            state_nxt   = ST_STALL;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush = 1'b1;
          if (fcnt == '0) state_nxt = ST_RUN;
          else            fcnt_nxt  = fcnt - FLUSH_CNT_W'(1);
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign ifid_flush = flush;
  assign idex_flush = flush;

  sat_counter #(.WIDTH(PCSRC_W)) u_pcsrc_cnt (
    .clk(clk), .rst_n(rst_n), .clr(flush), .en(pc_write), .q(pcsrc_counter)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(stall_evt), .q(stall_count)
  );

  sat_counter #(.WIDTH(STAT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(mp_evt), .q(flush_count)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: per-cycle check against an event-level model plus literal spot checks.
module tb_hazard_control_unit;
  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
  logic        ifid_uses_rs2 = 1'b0, ex_mispredict = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
  logic [2:0]  pcsrc_counter;
  logic [15:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_fail = 0;

  // model state: remaining forced-flush cycles, stall-just-taken flag, counters
  int m_flush_left = 0;
  bit m_stall = 0;
  int m_pc = 0, m_stall_cnt = 0, m_flush_cnt = 0;

  hazard_control_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .ex_mispredict(ex_mispredict), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pcsrc_counter(pcsrc_counter), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // 0 reset, 1 flushing, 2 accept mispredict, 3 stall, 4 idle
  function automatic int decide();
    bit lu;
    lu = idex_memread && idex_rd != 0 &&
         (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    if (!rst_n)               return 0;
    if (m_flush_left > 0)     return 1;
    if (ex_mispredict)        return 2;
    if (!m_stall && lu)       return 3;
    return 4;
  endfunction

  always @(posedge clk) begin
    int d;
    d = decide();
    case (d)
      0: begin m_flush_left = 0; m_stall = 0; m_pc = 0; m_stall_cnt = 0; m_flush_cnt = 0; end
      1: begin m_flush_left--; m_stall = 0; m_pc = 0; end
      2: begin m_flush_left = FC - 1; m_stall = 0; m_pc = 0;
               if (m_flush_cnt < 65535) m_flush_cnt++; end
      3: begin m_stall = 1; if (m_stall_cnt < 65535) m_stall_cnt++; end
      default: begin m_stall = 0; if (m_pc < 7) m_pc++; end
    endcase
  end

  always @(negedge clk) begin
    int d;
    logic [4:0] exp_ctl, act_ctl;
    d = decide();
    exp_ctl = {d != 3, d != 3, d == 3, d == 1 || d == 2, d == 1 || d == 2};
    act_ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush};
    n_cmp++;
    if (act_ctl !== exp_ctl || pcsrc_counter !== 3'(m_pc) ||
        stall_count !== 16'(m_stall_cnt) || flush_count !== 16'(m_flush_cnt)) begin
      n_fail++;
      $display("FAIL cycle t=%0t ctl act=%b exp=%b pcsrc act=%0d exp=%0d stall act=%0d exp=%0d flush act=%0d exp=%0d",
               $time, act_ctl, exp_ctl, pcsrc_counter, m_pc, stall_count, m_stall_cnt,
               flush_count, m_flush_cnt);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_uses_rs2 = 0; ex_mispredict = 0;
  endtask

  task automatic lu_in(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic uses2);
    idex_memread = 1; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = uses2;
  endtask

  initial begin
    tick(); tick();
    chk("reset_pcsrc", pcsrc_counter, 0);
    chk("reset_stall", stall_count, 0);
    chk("reset_pcw", pc_write, 1);
    rst_n = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("idle_pcsrc", pcsrc_counter, (k < 7) ? k : 7);
      chk("idle_pcw", pc_write, 1);
    end

    // simultaneous load-use and mispredict: flush wins
    lu_in(5, 0, 5, 1); ex_mispredict = 1; #1;
    chk("mp_pri_flush", ifid_flush, 1);
    chk("mp_pri_bubble", idex_bubble, 0);
    tick(); idle_in(); ex_mispredict = 1; #1;   // N+1, ignored mispredict
    chk("mp_flush_cnt", flush_count, 1);
    chk("mp_stall_cnt", stall_count, 0);
    chk("mp_pcsrc0", pcsrc_counter, 0);
    chk("mp_n1_flush", idex_flush, 1);
    tick(); ex_mispredict = 0; #1;              // N+2
    chk("mp_n2_flush", ifid_flush, 1);
    chk("mp_n1_ignored", flush_count, 1);
    tick();                                     // N+3
    chk("mp_n3_run", ifid_flush, 0);
    tick(); tick();
    chk("mp_pcsrc2", pcsrc_counter, 2);

    // load-use via rs2
    lu_in(5, 0, 5, 1); #1;
    chk("lu_pcw", pc_write, 0);
    chk("lu_bubble", idex_bubble, 1);
    tick();
    chk("lu_stall_cnt", stall_count, 1);
    chk("lu_pcsrc_held", pcsrc_counter, 2);
    chk("lu_masked", idex_bubble, 0);
    idle_in(); tick();
    lu_in(0, 0, 0, 1); #1;
    chk("lu_rd0", pc_write, 1);
    lu_in(7, 1, 7, 0); #1;
    chk("lu_no_rs2", idex_bubble, 0);
    lu_in(9, 9, 0, 0); #1;
    chk("lu_rs1", idex_bubble, 1);
    tick(); idle_in(); tick();

    // reset during STALL
    lu_in(3, 3, 0, 0); tick(); idle_in(); rst_n = 0; #1;
    chk("rst_pcw", pc_write, 1);
    tick(); rst_n = 1; #1;
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_bubble", idex_bubble, 0);
    tick();

    // reset during FLUSH
    ex_mispredict = 1; tick(); ex_mispredict = 0; rst_n = 0; tick(); rst_n = 1; #1;
    chk("rstf_flush", idex_flush, 0);
    chk("rstf_flush_cnt", flush_count, 0);
    tick();

    // last-FLUSH-cycle mispredict ignored, next RUN one restarts
    ex_mispredict = 1; tick(); ex_mispredict = 0; tick(); ex_mispredict = 1; tick();
    chk("mp_last_ign", flush_count, 1);
    #1; chk("mp_restart", ifid_flush, 1);
    tick(); ex_mispredict = 0;
    chk("mp_restart_cnt", flush_count, 2);
    tick(); tick(); tick();

    // stall counter saturation
    force dut.u_stall_cnt.q = 16'hFFFF;
    m_stall_cnt = 65535;
    tick();
    release dut.u_stall_cnt.q;
    lu_in(4, 4, 0, 0); tick(); idle_in(); tick();
    chk("stall_sat", stall_count, 65535);

    // mixed directed traffic, model-checked each cycle
    for (int i = 0; i < 60; i++) begin
      idex_memread  = $urandom_range(0, 1);
      idex_rd       = 5'($urandom_range(0, 3));
      ifid_rs1      = 5'($urandom_range(0, 3));
      ifid_rs2      = 5'($urandom_range(0, 3));
      ifid_uses_rs2 = $urandom_range(0, 1);
      ex_mispredict = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_in(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
